// File: rtl/mtc_matcher.sv
// mtc_matcher: pairs per-slot SL pipeline words with pT-calc results.
//
// Each of the n_PRIMARY_MTC slots captures one SL word and waits for a pT word
// tagged with its index. A hit emits {matched=1, timeout=0, sl, pt}. If nothing
// arrives within TIMEOUT cycles, it emits {matched=0, timeout=1, sl, 0}.
// Emission is registered: mtc_valid pulses for one cycle, and mtc holds the
// last word.
//
// Ports:
//   clock          rising-edge clock
//   rst            asynchronous active-low reset
//   srst           synchronous active-high clear (same effect as rst)
//   ptcalc         c_NUM_THREADS pT words, thread t at [t*PTCALC_WIDTH +: PTCALC_WIDTH]
//   ptcalc_valid   per-thread valid
//   ptcalc_tag     per-thread destination slot, thread t at [t*TAG_W +: TAG_W]
//   sl             n_PRIMARY_MTC SL words, slot i at [i*SLCPIPELINE_WIDTH +: ...]
//   sl_valid       per-slot valid
//   mtc            per-slot output words {matched, timeout, sl, pt}
//   mtc_valid      per-slot one-cycle emission pulse
//   cnt_sl_drop    saturating count of SL words discarded while a slot was busy
//   cnt_pt_orphan  saturating count of pT words with no receptive slot
//   cnt_pt_collide saturating count of pT words that lost to a lower thread
module mtc_matcher #(
  parameter int unsigned PTCALC_WIDTH      = 64,
  parameter int unsigned SLCPIPELINE_WIDTH = 128,
  parameter int unsigned c_NUM_THREADS     = 3,
  parameter int unsigned n_PRIMARY_MTC     = 3,
  parameter int unsigned TIMEOUT           = 32,
  localparam int unsigned TAG_W      = (n_PRIMARY_MTC > 1) ? $clog2(n_PRIMARY_MTC) : 1,
  localparam int unsigned MTC2SL_LEN = SLCPIPELINE_WIDTH + PTCALC_WIDTH + 2
) (
  input  logic                                        clock,
  input  logic                                        rst,
  input  logic                                        srst,
  input  logic [PTCALC_WIDTH*c_NUM_THREADS-1:0]       ptcalc,
  input  logic [c_NUM_THREADS-1:0]                    ptcalc_valid,
  input  logic [TAG_W*c_NUM_THREADS-1:0]              ptcalc_tag,
  input  logic [SLCPIPELINE_WIDTH*n_PRIMARY_MTC-1:0]  sl,
  input  logic [n_PRIMARY_MTC-1:0]                    sl_valid,
  output logic [MTC2SL_LEN*n_PRIMARY_MTC-1:0]         mtc,
  output logic [n_PRIMARY_MTC-1:0]                    mtc_valid,
  output logic [15:0]                                 cnt_sl_drop,
  output logic [15:0]                                 cnt_pt_orphan,
  output logic [15:0]                                 cnt_pt_collide
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam int unsigned SL_W  = SLCPIPELINE_WIDTH;
  localparam int unsigned PT_W  = PTCALC_WIDTH;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e             state_q [n_PRIMARY_MTC];
  state_e             state_d [n_PRIMARY_MTC];
  logic [CNT_W-1:0]   cnt_q   [n_PRIMARY_MTC];
  logic [CNT_W-1:0]   cnt_d   [n_PRIMARY_MTC];
  logic [SL_W-1:0]    sl_q    [n_PRIMARY_MTC];
  logic [SL_W-1:0]    sl_d    [n_PRIMARY_MTC];

  logic [MTC2SL_LEN*n_PRIMARY_MTC-1:0] mtc_q, mtc_d;
  logic [n_PRIMARY_MTC-1:0]            mtc_valid_q, mtc_valid_d;
  logic [15:0] drop_q, drop_d, orphan_q, orphan_d, collide_q, collide_d;

  // Per-cycle event tallies and hit resolution results.
  logic [15:0]        drop_inc, orphan_inc, collide_inc;
  logic [TAG_W-1:0]   tags     [c_NUM_THREADS];
  logic               hit_found[n_PRIMARY_MTC];
  logic [PT_W-1:0]    hit_pt   [n_PRIMARY_MTC];
  logic               receptive[n_PRIMARY_MTC];

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    drop_inc    = '0;
    orphan_inc  = '0;
    collide_inc = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sl_d        = sl_q;
    mtc_d       = mtc_q;
    mtc_valid_d = '0;

    for (int t = 0; t < int'(c_NUM_THREADS); t++) begin
      tags[t] = ptcalc_tag[t*TAG_W +: TAG_W];
      if (ptcalc_valid[t] && (int'(tags[t]) >= int'(n_PRIMARY_MTC))) begin
        orphan_inc = orphan_inc + 16'd1;
      end
    end

    for (int i = 0; i < int'(n_PRIMARY_MTC); i++) begin
      hit_found[i] = 1'b0;
      hit_pt[i]    = '0;
      // A slot can take a pT while waiting, or in the same cycle its SL arrives.
      receptive[i] = (state_q[i] == StWait) || sl_valid[i];
      // Ascending thread order gives the lowest index priority.
      for (int t = 0; t < int'(c_NUM_THREADS); t++) begin
        if (ptcalc_valid[t] && (tags[t] == TAG_W'(i))) begin
          if (!receptive[i]) begin
            orphan_inc = orphan_inc + 16'd1;
          end else if (hit_found[i]) begin
            collide_inc = collide_inc + 16'd1;
          end else begin
            hit_found[i] = 1'b1;
            hit_pt[i]    = ptcalc[t*PT_W +: PT_W];
          end
        end
      end

      case (state_q[i])
        StIdle: begin
          if (sl_valid[i]) begin
            if (hit_found[i]) begin
              mtc_d[i*MTC2SL_LEN +: MTC2SL_LEN] =
                {1'b1, 1'b0, sl[i*SL_W +: SL_W], hit_pt[i]};
              mtc_valid_d[i] = 1'b1;
            end else begin
              state_d[i] = StWait;
              cnt_d[i]   = '0;
              sl_d[i]    = sl[i*SL_W +: SL_W];
            end
          end
        end
        StWait: begin
          // Any SL arriving while busy is lost, including on the resolving cycle.
          if (sl_valid[i]) begin
            drop_inc = drop_inc + 16'd1;
          end
          if (hit_found[i]) begin
            mtc_d[i*MTC2SL_LEN +: MTC2SL_LEN] = {1'b1, 1'b0, sl_q[i], hit_pt[i]};
            mtc_valid_d[i] = 1'b1;
            state_d[i]     = StIdle;
          end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
            mtc_d[i*MTC2SL_LEN +: MTC2SL_LEN] = {1'b0, 1'b1, sl_q[i], {PT_W{1'b0}}};
            mtc_valid_d[i] = 1'b1;
            state_d[i]     = StIdle;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end

    drop_d    = sat_add(drop_q, drop_inc);
    orphan_d  = sat_add(orphan_q, orphan_inc);
    collide_d = sat_add(collide_q, collide_inc);

    // Synchronous clear abandons waiting slots without emitting.
    if (srst) begin
      for (int i = 0; i < int'(n_PRIMARY_MTC); i++) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
        sl_d[i]    = '0;
      end
      mtc_d       = '0;
      mtc_valid_d = '0;
      drop_d      = '0;
      orphan_d    = '0;
      collide_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(n_PRIMARY_MTC); i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        sl_q[i]    <= '0;
      end
      mtc_q       <= '0;
      mtc_valid_q <= '0;
      drop_q      <= '0;
      orphan_q    <= '0;
      collide_q   <= '0;
    end else begin
      for (int i = 0; i < int'(n_PRIMARY_MTC); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        sl_q[i]    <= sl_d[i];
      end
      mtc_q       <= mtc_d;
      mtc_valid_q <= mtc_valid_d;
      drop_q      <= drop_d;
      orphan_q    <= orphan_d;
      collide_q   <= collide_d;
    end
  end

  assign mtc            = mtc_q;
  assign mtc_valid      = mtc_valid_q;
  assign cnt_sl_drop    = drop_q;
  assign cnt_pt_orphan  = orphan_q;
  assign cnt_pt_collide = collide_q;

endmodule

// File: doc/mtc_matcher.md
MTC_MATCHER -- requirements
Module: mtc_matcher

Interface
REQ-001 SHALL have parameter PTCALC_WIDTH, default 64, width of one pT-calc result word.
REQ-002 SHALL have parameter SLCPIPELINE_WIDTH, default 128, width of one SL pipeline word.
REQ-003 SHALL have parameter c_NUM_THREADS, default 3, number of pT-calc threads (1..8).
REQ-004 SHALL have parameter n_PRIMARY_MTC, default 3, number of SL slots/MTC outputs (1..8).
REQ-005 SHALL have parameter TIMEOUT, default 32, cycles a slot waits for pT before fallback emission (>=2).
REQ-006 SHALL have derived constants TAG_W = max(1, clog2(n_PRIMARY_MTC)) and MTC2SL_LEN = SLCPIPELINE_WIDTH+PTCALC_WIDTH+2.
REQ-007 clock  in  1  single clock; all logic rising-edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 srst  in  1  synchronous clear, active-high, same effect as rst.
REQ-010 ptcalc  in  PTCALC_WIDTH*c_NUM_THREADS  thread t at bits [t*PTCALC_WIDTH +: PTCALC_WIDTH].
REQ-011 ptcalc_valid  in  c_NUM_THREADS  per-thread valid.
REQ-012 ptcalc_tag  in  TAG_W*c_NUM_THREADS  per-thread destination slot index.
REQ-013 sl  in  SLCPIPELINE_WIDTH*n_PRIMARY_MTC  slot i at [i*SLCPIPELINE_WIDTH +: SLCPIPELINE_WIDTH].
REQ-014 sl_valid  in  n_PRIMARY_MTC  per-slot valid.
REQ-015 mtc  out  MTC2SL_LEN*n_PRIMARY_MTC  slot i word = {matched, timeout, sl, pt} at [i*MTC2SL_LEN +: MTC2SL_LEN], matched MSB.
REQ-016 mtc_valid  out  n_PRIMARY_MTC  one-cycle pulse per emitted word.
REQ-017 cnt_sl_drop, cnt_pt_orphan, cnt_pt_collide  out  16 each  saturating event counters.

Function
REQ-018 Each slot SHALL run an independent FSM with states IDLE and WAIT plus a timeout counter.
REQ-019 IDLE with sl_valid[i]=1: SHALL capture sl word, clear counter, go WAIT.
REQ-020 WAIT: counter SHALL increment each cycle; on a pT hit for slot i SHALL go IDLE and emit matched=1, timeout=0, captured sl, pt word.
REQ-021 WAIT with counter = TIMEOUT-1 and no hit: SHALL go IDLE and emit matched=0, timeout=1, captured sl, pt field all zeros.
REQ-022 A pT hit is ptcalc_valid[t]=1 with ptcalc_tag[t]=i; tags >= n_PRIMARY_MTC SHALL be treated as orphans.
REQ-023 pT hit in same cycle as sl_valid[i] in IDLE SHALL match immediately (bypass): emission next cycle, slot stays IDLE.
REQ-024 Emission latency SHALL be exactly one cycle: mtc/mtc_valid registered, asserted in cycle after resolving event.
REQ-025 mtc SHALL hold last emitted word when mtc_valid=0.
REQ-026 Slot returning to IDLE in cycle t SHALL accept sl_valid[i] in cycle t+1.
REQ-027 sl_valid[i] while slot in WAIT (and not resolving that cycle) SHALL be discarded and cnt_sl_drop incremented; sl_valid in the resolving cycle also discarded.
REQ-028 Multiple threads hitting the same slot in one cycle: lowest thread index SHALL win; each loser increments cnt_pt_collide by one (total losers per cycle added).
REQ-029 Valid pT whose slot is IDLE without same-cycle sl_valid, or tag out of range, SHALL be discarded and increment cnt_pt_orphan.
REQ-030 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-031 Hit and timeout in same cycle: hit SHALL take precedence (matched=1, timeout=0).

Reset
REQ-032 rst=0 SHALL asynchronously force all slots IDLE, counters to 0, mtc to 0, mtc_valid to 0, event counters to 0.
REQ-033 srst=1 SHALL do the same at the next rising edge; pending WAIT slots SHALL be abandoned without emission.
REQ-034 Inputs during reset SHALL be ignored; first capture is on the first edge with rst=1, srst=0.

Verification
REQ-035 sl_valid[0]=1 at cycle 0, ptcalc_valid[1]=1 tag=0 pt=0x55 at cycle 3 -> mtc_valid[0] at cycle 4, matched=1, pt field=0x55.
REQ-036 sl_valid[2]=1, no pT, TIMEOUT=32 -> mtc_valid[2] exactly 32 cycles after capture edge, matched=0, timeout=1, pt=0.
REQ-037 sl_valid[1] and ptcalc_valid[0] tag=1 same cycle -> mtc_valid[1] next cycle matched=1; cnt_pt_orphan stays 0.
REQ-038 Threads 0,1,2 all valid tag=0 with slot 0 WAIT -> pt from thread 0 emitted, cnt_pt_collide=2.
REQ-039 Second sl_valid[0] while WAIT -> cnt_sl_drop=1, first sl word emitted unchanged.
REQ-040 rst low mid-WAIT then released -> no mtc_valid pulse, all counters 0, new sl accepted next cycle.
